pea_dma_xbar: RTL and testbench

//  Output-side crossbar: routes PEA output lanes of one output stream to that stream's DMA channels.

---
 rtl/pea_pkg.sv | 6 +
 rtl/stream_intf_pkg.sv | 9 +
 rtl/pea_dma_ch_fifo.sv | 73 +++++++
 rtl/pea_dma_xbar.sv | 102 ++++++++++
 tb/tb_pea_dma_xbar.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pea_pkg.sv
// PEA datapath constants.
package pea_pkg;

    localparam int N_BITS = 32;

endpackage

// File: rtl/stream_intf_pkg.sv
// Stream interface sizing shared by the PEA input and output crossbars.
package stream_intf_pkg;

    localparam int N_DMA_CH_PER_OUT_STREAM   = 4;
    localparam int N_PEA_DOUT_PER_OUT_STREAM = 4;

    typedef logic [$clog2(N_PEA_DOUT_PER_OUT_STREAM)-1:0] out_xbar_sel_t;

endpackage

// File: rtl/pea_dma_ch_fifo.sv
// Per-channel FIFO between a PEA lane and one DMA channel; head word is registered.
module pea_dma_ch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]                wr_q, wr_d;
    logic [PW-1:0]                rd_q, rd_d;
    logic [PW:0]                  cnt_q, cnt_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
    logic                         wr_en;
    logic                         rd_en;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push_i & (~full_o | pop_i);
    assign rd_en = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_q] = din_i;
                wr_d        = wr_q + 1'b1;
            end
            if (rd_en) begin
                rd_d = rd_q + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            mem_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pea_dma_xbar.sv
// Output crossbar: each DMA channel picks one PEA lane and buffers it in a FIFO,
// since the PEA cannot be stalled; dropped words are flagged and counted.
module pea_dma_xbar
    import stream_intf_pkg::*;
    import pea_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          flush_i,
    input  logic                                          cfg_we_i,
    input  out_xbar_sel_t [N_DMA_CH_PER_OUT_STREAM-1:0]   sel_i,
    input  logic [N_DMA_CH_PER_OUT_STREAM-1:0]            en_i,
    input  logic [N_PEA_DOUT_PER_OUT_STREAM-1:0]          pea_valid_i,
    input  logic [N_PEA_DOUT_PER_OUT_STREAM-1:0][N_BITS-1:0] pea_dout_i,
    output logic [N_DMA_CH_PER_OUT_STREAM-1:0]            dma_ch_valid_o,
    output logic [N_DMA_CH_PER_OUT_STREAM-1:0][N_BITS-1:0] dma_ch_dout_o,
    input  logic [N_DMA_CH_PER_OUT_STREAM-1:0]            dma_ch_ready_i,
    output logic [N_DMA_CH_PER_OUT_STREAM-1:0]            ovf_o,
    output logic [N_DMA_CH_PER_OUT_STREAM-1:0][15:0]      ovf_cnt_o
);

    localparam int N_CH = N_DMA_CH_PER_OUT_STREAM;

    out_xbar_sel_t [N_CH-1:0]              sel_q;
    logic [N_CH-1:0]                       en_q;
    logic [N_CH-1:0]                       ovf_q, ovf_d;
    logic [N_CH-1:0][15:0]                 ovf_cnt_q, ovf_cnt_d;
    logic [N_CH-1:0]                       push;
    logic [N_CH-1:0]                       pop;
    logic [N_CH-1:0]                       full;
    logic [N_CH-1:0]                       empty;
    logic [N_CH-1:0][N_BITS-1:0]           push_data;

    always_comb begin
        push      = '0;
        pop       = '0;
        push_data = '0;
        for (int j = 0; j < N_CH; j++) begin
            push[j]      = en_q[j] & pea_valid_i[sel_q[j]];
            push_data[j] = pea_dout_i[sel_q[j]];
            pop[j]       = ~empty[j] & dma_ch_ready_i[j];
        end
    end

    always_comb begin
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (flush_i) begin
            ovf_d     = '0;
            ovf_cnt_d = '0;
        end else begin
            for (int j = 0; j < N_CH; j++) begin
                if (push[j] & full[j] & ~pop[j]) begin
                    ovf_d[j] = 1'b1;
                    if (ovf_cnt_q[j] != 16'hFFFF) begin
                        ovf_cnt_d[j] = ovf_cnt_q[j] + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q     <= '0;
            en_q      <= '0;
            ovf_q     <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (cfg_we_i) begin
                sel_q <= sel_i;
                en_q  <= en_i;
            end
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    for (genvar j = 0; j < N_CH; j++) begin : g_ch
        pea_dma_ch_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (N_BITS)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (push[j]),
            .pop_i   (pop[j]),
            .din_i   (push_data[j]),
            .dout_o  (dma_ch_dout_o[j]),
            .full_o  (full[j]),
            .empty_o (empty[j])
        );
    end

    assign dma_ch_valid_o = ~empty;
    assign ovf_o          = ovf_q;
    assign ovf_cnt_o      = ovf_cnt_q;

endmodule

// File: tb/tb_pea_dma_xbar.sv
// Directed bench for pea_dma_xbar: vector table for channel-0 FIFO behaviour plus
// hand sequences for routing, fan-out and asynchronous reset.
module tb_pea_dma_xbar;
    import stream_intf_pkg::*;

    logic                        clk;
    logic                        rst;
    logic                        flush;
    logic                        cfg_we;
    out_xbar_sel_t [3:0]         sel;
    logic [3:0]                  en;
    logic [3:0]                  pv;
    logic [3:0][31:0]            pdout;
    logic [3:0]                  valid;
    logic [3:0][31:0]            dout;
    logic [3:0]                  rdy;
    logic [3:0]                  ovf;
    logic [3:0][15:0]            cnt;

    int n_chk;
    int n_err;

    pea_dma_xbar #(.FIFO_DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .cfg_we_i       (cfg_we),
        .sel_i          (sel),
        .en_i           (en),
        .pea_valid_i    (pv),
        .pea_dout_i     (pdout),
        .dma_ch_valid_o (valid),
        .dma_ch_dout_o  (dout),
        .dma_ch_ready_i (rdy),
        .ovf_o          (ovf),
        .ovf_cnt_o      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        cfg;
        logic        pv;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        eo;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic f, input logic c, input logic p,
                                input logic [31:0] d, input logic r,
                                input logic ev, input logic [31:0] ed,
                                input logic eo, input logic [15:0] ec);
        vec_t v;
        v.flush = f; v.cfg = c; v.pv = p; v.d = d; v.rdy = r;
        v.ev = ev; v.ed = ed; v.eo = eo; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic lanes(input logic [31:0] d);
        for (int k = 0; k < 4; k++) pdout[k] = d + 32'(k);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        cfg_we = 1'b0;
        sel    = '0;
        en     = '0;
        pv     = '0;
        rdy    = '0;
        lanes(32'h0);

        // reset state
        #3;
        chk("reset valid", 64'(valid), 64'h0);
        chk("reset dout0", 64'(dout[0]), 64'h0);
        chk("reset ovf", 64'(ovf), 64'h0);
        chk("reset cnt0", 64'(cnt[0]), 64'h0);
        #9 rst = 1'b0;
        tick();

        // routing: ch3 picks lane0, others pick lanes 3..1
        cfg_we = 1'b1;
        sel[0] = 2'd3; sel[1] = 2'd2; sel[2] = 2'd1; sel[3] = 2'd0;
        en  = 4'hF;
        rdy = 4'hF;
        tick();
        cfg_we = 1'b0;
        pv = 4'b0001;
        lanes(32'hA5);
        tick();
        chk("route valid", 64'(valid), 64'h8);
        chk("route dout3", 64'(dout[3]), 64'hA5);
        pv = 4'b0000;
        tick();
        chk("route drained", 64'(valid), 64'h0);

        // fan-out of lane0 to all channels, one word per cycle
        cfg_we = 1'b1;
        sel = '0;
        tick();
        cfg_we = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pv = 4'b0001;
            lanes(32'(i));
            tick();
            chk($sformatf("fanout%0d valid", i), 64'(valid), 64'hF);
            for (int j = 0; j < 4; j++)
                chk($sformatf("fanout%0d dout%0d", i, j), 64'(dout[j]), 64'(i));
        end
        pv = 4'b0000;
        tick();
        chk("fanout end valid", 64'(valid), 64'h0);
        chk("fanout end ovf", 64'(ovf), 64'h0);

        // channel-0 table: back-pressure, full push+pop, flush
        tbl[0]  = mk(0, 1, 0, 0,  0, 0, 0,  0, 0);
        tbl[1]  = mk(0, 0, 1, 1,  0, 1, 1,  0, 0);
        tbl[2]  = mk(0, 0, 1, 2,  0, 1, 1,  0, 0);
        tbl[3]  = mk(0, 0, 1, 3,  0, 1, 1,  0, 0);
        tbl[4]  = mk(0, 0, 1, 4,  0, 1, 1,  0, 0);
        tbl[5]  = mk(0, 0, 1, 5,  0, 1, 1,  1, 1);
        tbl[6]  = mk(0, 0, 1, 6,  0, 1, 1,  1, 2);
        tbl[7]  = mk(0, 0, 0, 0,  1, 1, 2,  1, 2);
        tbl[8]  = mk(0, 0, 0, 0,  1, 1, 3,  1, 2);
        tbl[9]  = mk(0, 0, 0, 0,  1, 1, 4,  1, 2);
        tbl[10] = mk(0, 0, 0, 0,  1, 0, 0,  1, 2);
        tbl[11] = mk(0, 0, 1, 11, 0, 1, 11, 1, 2);
        tbl[12] = mk(0, 0, 1, 12, 0, 1, 11, 1, 2);
        tbl[13] = mk(0, 0, 1, 13, 0, 1, 11, 1, 2);
        tbl[14] = mk(0, 0, 1, 14, 0, 1, 11, 1, 2);
        tbl[15] = mk(0, 0, 1, 15, 1, 1, 12, 1, 2);
        tbl[16] = mk(0, 0, 1, 16, 0, 1, 12, 1, 3);
        tbl[17] = mk(0, 0, 0, 0,  1, 1, 13, 1, 3);
        tbl[18] = mk(0, 0, 0, 0,  1, 1, 14, 1, 3);
        tbl[19] = mk(0, 0, 0, 0,  1, 1, 15, 1, 3);
        tbl[20] = mk(0, 0, 0, 0,  1, 0, 0,  1, 3);
        tbl[21] = mk(0, 0, 1, 21, 0, 1, 21, 1, 3);
        tbl[22] = mk(0, 0, 1, 22, 0, 1, 21, 1, 3);
        tbl[23] = mk(0, 0, 1, 23, 0, 1, 21, 1, 3);
        tbl[24] = mk(1, 0, 1, 24, 0, 0, 0,  0, 0);
        tbl[25] = mk(0, 0, 0, 0,  1, 0, 0,  0, 0);
        tbl[26] = mk(0, 0, 1, 26, 0, 1, 26, 0, 0);
        tbl[27] = mk(0, 0, 0, 0,  1, 0, 0,  0, 0);

        sel = '0;
        en  = 4'b0001;
        for (int i = 0; i < 28; i++) begin
            flush  = tbl[i].flush;
            cfg_we = tbl[i].cfg;
            pv     = {3'b000, tbl[i].pv};
            lanes(tbl[i].d);
            rdy    = {3'b111, tbl[i].rdy};
            tick();
            chk($sformatf("row%0d valid", i), 64'(valid), 64'({3'b000, tbl[i].ev}));
            if (tbl[i].ev)
                chk($sformatf("row%0d dout0", i), 64'(dout[0]), 64'(tbl[i].ed));
            chk($sformatf("row%0d ovf", i), 64'(ovf), 64'({3'b000, tbl[i].eo}));
            chk($sformatf("row%0d cnt0", i), 64'(cnt[0]), 64'(tbl[i].ec));
        end
        flush  = 1'b0;
        cfg_we = 1'b0;

        // asynchronous reset in the middle of a stalled burst
        cfg_we = 1'b1;
        en     = 4'hF;
        rdy    = 4'h0;
        pv     = 4'b0000;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pv = 4'b0001;
            lanes(32'h60 + 32'(i));
            tick();
        end
        pv = 4'b0000;
        chk("burst valid", 64'(valid), 64'hF);
        chk("burst ovf", 64'(ovf), 64'hF);
        chk("burst cnt2", 64'(cnt[2]), 64'h2);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", 64'(valid), 64'h0);
        chk("async rst ovf", 64'(ovf), 64'h0);
        chk("async rst cnt2", 64'(cnt[2]), 64'h0);
        chk("async rst dout1", 64'(dout[1]), 64'h0);
        #2 rst = 1'b0;
        tick();
        pv  = 4'b0001;
        rdy = 4'hF;
        lanes(32'h77);
        tick();
        chk("post rst disabled", 64'(valid), 64'h0);
        pv     = 4'b0000;
        cfg_we = 1'b1;
        sel    = '0;
        en     = 4'hF;
        tick();
        cfg_we = 1'b0;
        pv = 4'b0001;
        lanes(32'h88);
        tick();
        chk("post cfg valid", 64'(valid), 64'hF);
        chk("post cfg dout2", 64'(dout[2]), 64'h88);
        pv = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
